// File: rtl/pcie_rd_pkg.sv
// Shared types and helpers for the PCIe read-request splitter.
// Optional 4 KB boundary splitting is enabled by defining PCIE_RD_4K_SPLIT_EN.
package pcie_rd_pkg;

  localparam int unsigned ADDR_W        = 64;
  localparam int unsigned CNT_W         = 24;
  localparam int unsigned LEN_W         = 10;
  localparam int unsigned MRRS_SEL_W    = 3;
  localparam int unsigned MRRS_DW_W     = 11;
  localparam int unsigned MRRS_SEL_MAX  = 5;   // 4096 B
  localparam int unsigned MRRS_BASE_DW  = 32;  // 128 B

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    WAIT_CREDIT,
    ISSUE,
    DONE
  } state_e;

  // MRRS select to dwords; 6 and 7 alias to 4096 B.
  function automatic logic [MRRS_DW_W-1:0] mrrs_to_dw(input logic [MRRS_SEL_W-1:0] sel);
    logic [MRRS_SEL_W-1:0] sel_c;
    sel_c = (sel > MRRS_SEL_W'(MRRS_SEL_MAX)) ? MRRS_SEL_W'(MRRS_SEL_MAX) : sel;
    return MRRS_DW_W'(MRRS_BASE_DW) << sel_c;
  endfunction

endpackage

// File: rtl/pcie_rd_chunk_calc.sv
// Combinational chunk size: min of remaining, max_dw and (optionally) the 4 KB boundary.
// Boundary term is included only when PCIE_RD_4K_SPLIT_EN is defined.
module pcie_rd_chunk_calc
  import pcie_rd_pkg::*;
(
  input  logic [9:0]       i_addr_dw,
  input  logic [CNT_W-1:0] i_remaining,
  input  logic [LEN_W-1:0] i_max_dw,
  output logic [LEN_W-1:0] o_chunk
);

  logic [CNT_W-1:0] lim;

`ifdef PCIE_RD_4K_SPLIT_EN
  logic [10:0] bound4k;

  always_comb begin
    bound4k = 11'd1024 - {1'b0, i_addr_dw};
    lim     = CNT_W'(i_max_dw);
    if (CNT_W'(bound4k) < lim) lim = CNT_W'(bound4k);
  end
`else
  logic unused_addr_dw;

  assign unused_addr_dw = ^i_addr_dw;

  always_comb begin
    lim = CNT_W'(i_max_dw);
  end
`endif

  // lim never exceeds max_dw (<= 512), so the narrowing below is lossless.
  assign o_chunk = (i_remaining < lim) ? i_remaining[LEN_W-1:0] : lim[LEN_W-1:0];

endmodule

// File: rtl/pcie_rd_req_splitter.sv
// Splits one DMA read command into credit-gated PCIe memory-read requests.
// Define PCIE_RD_4K_SPLIT_EN to keep every request inside a 4 KB page.
module pcie_rd_req_splitter
  import pcie_rd_pkg::*;
#(
  parameter int unsigned TAG_WIDTH    = 5,
  parameter int unsigned MAX_CHUNK_DW = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [ADDR_W-1:0]     i_cmd_addr,
  input  logic [CNT_W-1:0]      i_cmd_dword_count,
  input  logic [MRRS_SEL_W-1:0] i_max_rd_req_sel,
  input  logic                  i_credit_ready,
  output logic [LEN_W-1:0]      o_credit_dword_req_count,
  output logic                  o_credit_cmt_stb,
  output logic                  o_req_valid,
  input  logic                  i_req_ready,
  output logic [ADDR_W-1:0]     o_req_addr,
  output logic [LEN_W-1:0]      o_req_dword_len,
  output logic [TAG_WIDTH-1:0]  o_req_tag,
  output logic                  o_busy,
  output logic                  o_done
);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [CNT_W-1:0]      rem_q, rem_d;
  logic [LEN_W-1:0]      max_dw_q, max_dw_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  req_valid_q, req_valid_d;
  logic                  done_q, done_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  busy_q, busy_d;

  logic [MRRS_DW_W-1:0]  mrrs_dw;
  logic [LEN_W-1:0]      sel_max_dw;
  logic [LEN_W-1:0]      chunk;
  logic [CNT_W-1:0]      rem_next;

  assign mrrs_dw    = mrrs_to_dw(i_max_rd_req_sel);
  assign sel_max_dw = (mrrs_dw > MRRS_DW_W'(MAX_CHUNK_DW)) ? LEN_W'(MAX_CHUNK_DW)
                                                           : mrrs_dw[LEN_W-1:0];
  assign rem_next   = rem_q - CNT_W'(len_q);

  pcie_rd_chunk_calc u_chunk_calc (
    .i_addr_dw   (addr_q[11:2]),
    .i_remaining (rem_q),
    .i_max_dw    (max_dw_q),
    .o_chunk     (chunk)
  );

  // Commit is a same-cycle acknowledge of credit ready while waiting.
  assign o_credit_cmt_stb = (state_q == WAIT_CREDIT) && i_credit_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    max_dw_d    = max_dw_q;
    len_d       = len_q;
    tag_d       = tag_q;
    req_valid_d = req_valid_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          addr_d   = i_cmd_addr & ~ADDR_W'(3);
          rem_d    = i_cmd_dword_count;
          max_dw_d = sel_max_dw;
          if (i_cmd_dword_count == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        len_d   = chunk;
        state_d = WAIT_CREDIT;
      end
      WAIT_CREDIT: begin
        if (i_credit_ready) begin
          req_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (req_valid_q && i_req_ready) begin
          addr_d      = addr_q + ADDR_W'({len_q, 2'b00});
          rem_d       = rem_next;
          tag_d       = tag_q + TAG_WIDTH'(1);
          req_valid_d = 1'b0;
          if (rem_next == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = CALC;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      max_dw_q    <= '0;
      len_q       <= '0;
      tag_q       <= '0;
      req_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      max_dw_q    <= max_dw_d;
      len_q       <= len_d;
      tag_q       <= tag_d;
      req_valid_q <= req_valid_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign o_cmd_ready              = cmd_ready_q;
  assign o_busy                   = busy_q;
  assign o_done                   = done_q;
  assign o_req_valid              = req_valid_q;
  assign o_req_addr               = addr_q;
  assign o_req_dword_len          = len_q;
  assign o_credit_dword_req_count = len_q;
  assign o_req_tag                = tag_q;

endmodule

// File: tb/tb_pcie_rd_req_splitter.sv
// Randomized self-checking bench for pcie_rd_req_splitter against a chunk-list model.
module tb_pcie_rd_req_splitter;

  localparam int unsigned TW = 5;

  logic          clk;
  logic          rst;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [63:0]   i_cmd_addr;
  logic [23:0]   i_cmd_dword_count;
  logic [2:0]    i_max_rd_req_sel;
  logic          i_credit_ready;
  logic [9:0]    o_credit_dword_req_count;
  logic          o_credit_cmt_stb;
  logic          o_req_valid;
  logic          i_req_ready;
  logic [63:0]   o_req_addr;
  logic [9:0]    o_req_dword_len;
  logic [TW-1:0] o_req_tag;
  logic          o_busy;
  logic          o_done;

  pcie_rd_req_splitter #(.TAG_WIDTH(TW), .MAX_CHUNK_DW(512)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .i_cmd_valid              (i_cmd_valid),
    .o_cmd_ready              (o_cmd_ready),
    .i_cmd_addr               (i_cmd_addr),
    .i_cmd_dword_count        (i_cmd_dword_count),
    .i_max_rd_req_sel         (i_max_rd_req_sel),
    .i_credit_ready           (i_credit_ready),
    .o_credit_dword_req_count (o_credit_dword_req_count),
    .o_credit_cmt_stb         (o_credit_cmt_stb),
    .o_req_valid              (o_req_valid),
    .i_req_ready              (i_req_ready),
    .o_req_addr               (o_req_addr),
    .o_req_dword_len          (o_req_dword_len),
    .o_req_tag                (o_req_tag),
    .o_busy                   (o_busy),
    .o_done                   (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit auto_rdy = 1'b0;
  int exp_tag = 0;

  // Observed transactions, recorded on the falling edge.
  int            n_cmt = 0;
  int            n_done = 0;
  int            viol = 0;
  logic [63:0]   obs_addr[$];
  logic [9:0]    obs_len[$];
  logic [TW-1:0] obs_tag[$];

  // Expected request list for the current command.
  longint unsigned exp_addr[$];
  int              exp_len[$];
  int              exp_tg[$];

  // Protocol monitor: commit before valid, one commit per request, stable while stalled.
  initial begin
    bit            pend;
    bit            hold_v;
    logic [63:0]   h_addr;
    logic [9:0]    h_len;
    logic [TW-1:0] h_tag;
    pend = 0;
    hold_v = 0;
    h_addr = '0;
    h_len = '0;
    h_tag = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0;
        hold_v = 0;
      end else begin
        if (hold_v && (!o_req_valid || o_req_addr !== h_addr ||
                       o_req_dword_len !== h_len || o_req_tag !== h_tag)) viol++;
        if (o_credit_cmt_stb) begin
          n_cmt++;
          if (pend || o_req_valid) viol++;
          pend = 1;
        end
        if (o_req_valid && !pend) viol++;
        if (o_req_valid && i_req_ready) begin
          obs_addr.push_back(o_req_addr);
          obs_len.push_back(o_req_dword_len);
          obs_tag.push_back(o_req_tag);
          pend = 0;
          hold_v = 0;
        end else if (o_req_valid) begin
          hold_v = 1;
          h_addr = o_req_addr;
          h_len = o_req_dword_len;
          h_tag = o_req_tag;
        end else begin
          hold_v = 0;
        end
        if (o_done) n_done++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (auto_rdy) begin
      i_credit_ready = ($urandom % 2) == 1;
      i_req_ready    = ($urandom % 2) == 1;
    end
  endtask

  // Reference: walk the command in chunks using the splitting rules directly.
  task automatic build_exp(input longint unsigned addr, input int count, input int sel);
    longint unsigned a;
    int rem, max_dw, c;
    exp_addr.delete();
    exp_len.delete();
    exp_tg.delete();
    a = addr & ~64'h3;
    rem = count;
    max_dw = 32 << ((sel > 5) ? 5 : sel);
    if (max_dw > 512) max_dw = 512;
    while (rem > 0) begin
      c = (rem < max_dw) ? rem : max_dw;
`ifdef PCIE_RD_4K_SPLIT_EN
      if (1024 - int'((a >> 2) & 64'd1023) < c) c = 1024 - int'((a >> 2) & 64'd1023);
`endif
      exp_addr.push_back(a);
      exp_len.push_back(c);
      exp_tg.push_back(exp_tag);
      a = a + 64'(c * 4);
      rem = rem - c;
      exp_tag = (exp_tag + 1) % (1 << TW);
    end
  endtask

  task automatic send_cmd(input logic [63:0] addr, input int count, input int sel);
    int cyc;
    cyc = 0;
    while (!o_cmd_ready && cyc < 100) begin
      step();
      cyc++;
    end
    i_cmd_addr = addr;
    i_cmd_dword_count = 24'(count);
    i_max_rd_req_sel = 3'(sel);
    i_cmd_valid = 1'b1;
    step();
    i_cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [63:0] addr, input int count, input int sel,
                         input string name, output int base);
    int b_cmt, b_done, b_viol, cyc, n;
    base = obs_addr.size();
    b_cmt = n_cmt;
    b_done = n_done;
    b_viol = viol;
    build_exp(addr, count, sel);
    send_cmd(addr, count, sel);
    cyc = 0;
    while (n_done == b_done && cyc < 6000) begin
      step();
      cyc++;
    end
    checks++;
    if (n_done - b_done != 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, n_done - b_done);
    end
    n = obs_addr.size() - base;
    checks++;
    if (n != exp_addr.size()) begin
      errors++;
      $display("FAIL %s req_count: got %0d expected %0d", name, n, exp_addr.size());
    end
    checks++;
    if (n_cmt - b_cmt != exp_addr.size()) begin
      errors++;
      $display("FAIL %s commit_count: got %0d expected %0d", name, n_cmt - b_cmt, exp_addr.size());
    end
    for (int i = 0; i < n && i < exp_addr.size(); i++) begin
      checks++;
      if (obs_addr[base+i] !== exp_addr[i] || obs_len[base+i] !== 10'(exp_len[i]) ||
          obs_tag[base+i] !== TW'(exp_tg[i])) begin
        errors++;
        $display("FAIL %s req%0d: got addr=%0h len=%0d tag=%0d expected addr=%0h len=%0d tag=%0d",
                 name, i, obs_addr[base+i], obs_len[base+i], obs_tag[base+i],
                 exp_addr[i], exp_len[i], exp_tg[i]);
      end
    end
    checks++;
    if (viol != b_viol) begin
      errors++;
      $display("FAIL %s protocol: got %0d violations expected 0", name, viol - b_viol);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 ||
        o_req_valid !== 1'b0 || o_credit_cmt_stb !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy=%b busy=%b done=%b vld=%b cmt=%b expected 1 0 0 0 0",
               o_cmd_ready, o_busy, o_done, o_req_valid, o_credit_cmt_stb);
    end
    checks++;
    if (o_req_addr !== 64'h0 || o_req_dword_len !== 10'h0 || o_req_tag !== '0 ||
        o_credit_dword_req_count !== 10'h0) begin
      errors++;
      $display("FAIL reset_data: got addr=%0h len=%0d tag=%0d cnt=%0d expected zeros",
               o_req_addr, o_req_dword_len, o_req_tag, o_credit_dword_req_count);
    end
  endtask

  task automatic test_basic();
    int base;
    auto_rdy = 1'b1;
    run_cmd(64'h1000, 100, 0, "basic", base);
    checks++;
    if (obs_addr.size() < base + 4 || obs_addr[base+3] !== 64'h1180 ||
        obs_len[base+3] !== 10'd4 || obs_tag[base+3] !== TW'(3)) begin
      errors++;
      $display("FAIL basic_last: got %0d reqs expected last (1180,4,3)", obs_addr.size() - base);
    end
  endtask

  task automatic test_4k();
    int base, exp_first;
`ifdef PCIE_RD_4K_SPLIT_EN
    exp_first = 16;
`else
    exp_first = 64;
`endif
    auto_rdy = 1'b1;
    run_cmd(64'h0FC0, 64, 2, "split4k", base);
    checks++;
    if (obs_len.size() <= base || obs_len[base] !== 10'(exp_first)) begin
      errors++;
      $display("FAIL split4k_first: got %0d reqs expected first len %0d",
               obs_len.size() - base, exp_first);
    end
  endtask

  task automatic test_credit_stall();
    int b_cmt, b_done, base, cyc;
    auto_rdy = 1'b0;
    i_credit_ready = 1'b0;
    i_req_ready = 1'b1;
    b_cmt = n_cmt;
    b_done = n_done;
    base = obs_addr.size();
    send_cmd(64'h2000, 40, 0);
    step();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (o_credit_dword_req_count !== 10'd32 || o_credit_cmt_stb !== 1'b0 || o_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL credit_wait%0d: got cnt=%0d cmt=%b vld=%b expected 32 0 0",
                 i, o_credit_dword_req_count, o_credit_cmt_stb, o_req_valid);
      end
      step();
    end
    i_credit_ready = 1'b1;
    #1;
    checks++;
    if (o_credit_cmt_stb !== 1'b1 || o_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL credit_commit: got cmt=%b vld=%b expected 1 0", o_credit_cmt_stb, o_req_valid);
    end
    step();
    i_credit_ready = 1'b0;
    #1;
    checks++;
    if (o_req_valid !== 1'b1 || o_credit_cmt_stb !== 1'b0) begin
      errors++;
      $display("FAIL credit_valid: got vld=%b cmt=%b expected 1 0", o_req_valid, o_credit_cmt_stb);
    end
    auto_rdy = 1'b1;
    cyc = 0;
    while (n_done == b_done && cyc < 500) begin
      step();
      cyc++;
    end
    checks++;
    if (n_cmt - b_cmt != 2 || obs_addr.size() - base != 2) begin
      errors++;
      $display("FAIL credit_totals: got cmt=%0d reqs=%0d expected 2 2",
               n_cmt - b_cmt, obs_addr.size() - base);
    end else begin
      checks++;
      if (obs_addr[base+1] !== 64'h2080 || obs_len[base+1] !== 10'd8 ||
          obs_tag[base] !== TW'(exp_tag)) begin
        errors++;
        $display("FAIL credit_reqs: got addr=%0h len=%0d tag0=%0d expected 2080 8 %0d",
                 obs_addr[base+1], obs_len[base+1], obs_tag[base], exp_tag);
      end
    end
    exp_tag = (exp_tag + 2) % (1 << TW);
  endtask

  task automatic test_req_stall();
    int b_cmt, b_done, cyc;
    logic [63:0]   a;
    logic [9:0]    l;
    logic [TW-1:0] t;
    auto_rdy = 1'b0;
    i_credit_ready = 1'b1;
    i_req_ready = 1'b0;
    b_done = n_done;
    send_cmd(64'h3000, 64, 0);
    cyc = 0;
    while (!o_req_valid && cyc < 50) begin
      step();
      cyc++;
    end
    a = o_req_addr;
    l = o_req_dword_len;
    t = o_req_tag;
    checks++;
    if (a !== 64'h3000 || l !== 10'd32 || t !== TW'(exp_tag)) begin
      errors++;
      $display("FAIL stall_first: got addr=%0h len=%0d tag=%0d expected 3000 32 %0d", a, l, t, exp_tag);
    end
    b_cmt = n_cmt;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (o_req_valid !== 1'b1 || o_req_addr !== a || o_req_dword_len !== l || o_req_tag !== t) begin
        errors++;
        $display("FAIL stall_hold%0d: got vld=%b addr=%0h len=%0d tag=%0d", i,
                 o_req_valid, o_req_addr, o_req_dword_len, o_req_tag);
      end
    end
    checks++;
    if (n_cmt != b_cmt) begin
      errors++;
      $display("FAIL stall_commit: got %0d extra commits expected 0", n_cmt - b_cmt);
    end
    i_req_ready = 1'b1;
    step();
    i_req_ready = 1'b0;
    cyc = 0;
    while (!o_req_valid && cyc < 50) begin
      step();
      cyc++;
    end
    checks++;
    if (o_req_valid !== 1'b1 || o_req_addr !== 64'h3080 || o_req_tag !== TW'(exp_tag + 1)) begin
      errors++;
      $display("FAIL stall_advance: got vld=%b addr=%0h tag=%0d expected 1 3080 %0d",
               o_req_valid, o_req_addr, o_req_tag, (exp_tag + 1) % (1 << TW));
    end
    i_req_ready = 1'b1;
    cyc = 0;
    while (n_done == b_done && cyc < 50) begin
      step();
      cyc++;
    end
    checks++;
    if (n_done - b_done != 1) begin
      errors++;
      $display("FAIL stall_done: got %0d expected 1", n_done - b_done);
    end
    exp_tag = (exp_tag + 2) % (1 << TW);
  endtask

  task automatic test_zero_count();
    int b_cmt, b_req;
    auto_rdy = 1'b1;
    b_cmt = n_cmt;
    b_req = obs_addr.size();
    send_cmd(64'h5000, 0, 3);
    checks++;
    if (o_done !== 1'b1) begin
      errors++;
      $display("FAIL zero_done: got %b expected 1", o_done);
    end
    step();
    step();
    checks++;
    if (o_done !== 1'b0 || o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_idle: got done=%b rdy=%b busy=%b expected 0 1 0", o_done, o_cmd_ready, o_busy);
    end
    checks++;
    if (n_cmt != b_cmt || obs_addr.size() != b_req) begin
      errors++;
      $display("FAIL zero_noreq: got cmt=%0d reqs=%0d expected 0 0", n_cmt - b_cmt, obs_addr.size() - b_req);
    end
  endtask

  task automatic test_big();
    int base;
    auto_rdy = 1'b1;
    run_cmd(64'h10_0000, 2000, 7, "big", base);
    checks++;
    if (obs_len.size() != base + 4 || obs_len[base] !== 10'd512 || obs_len[base+3] !== 10'd464) begin
      errors++;
      $display("FAIL big_chunks: got %0d reqs expected 512,512,512,464", obs_len.size() - base);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, base;
    auto_rdy = 1'b0;
    i_credit_ready = 1'b1;
    i_req_ready = 1'b0;
    send_cmd(64'h4000, 64, 0);
    cyc = 0;
    while (!o_req_valid && cyc < 50) begin
      step();
      cyc++;
    end
    rst = 1'b1;
    step();
    checks++;
    if (o_req_valid !== 1'b0 || o_busy !== 1'b0 || o_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst: got vld=%b busy=%b rdy=%b expected 0 0 1", o_req_valid, o_busy, o_cmd_ready);
    end
    rst = 1'b0;
    exp_tag = 0;
    auto_rdy = 1'b1;
    step();
    run_cmd(64'h6040, 70, 1, "after_rst", base);
    checks++;
    if (obs_tag.size() <= base || obs_tag[base] !== '0) begin
      errors++;
      $display("FAIL after_rst_tag: got %0d reqs expected first tag 0", obs_tag.size() - base);
    end
  endtask

  task automatic test_random();
    int base, cnt;
    logic [63:0] a;
    auto_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = {$urandom, $urandom};
      cnt = ($urandom % 4 == 0) ? int'($urandom_range(300, 1500)) : int'($urandom_range(1, 300));
      run_cmd(a, cnt, int'($urandom_range(0, 7)), "random", base);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_addr = '0;
    i_cmd_dword_count = '0;
    i_max_rd_req_sel = '0;
    i_credit_ready = 1'b0;
    i_req_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    test_reset();
    test_basic();
    test_4k();
    test_credit_stall();
    test_req_stall();
    test_zero_count();
    test_big();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
